md5_search_ctrl: RTL and testbench



---
 rtl/md5_search_pkg.sv | 26 ++
 rtl/md5_search_ctrl_if.sv | 37 +++
 rtl/md5_valid_pipe.sv | 28 ++
 rtl/md5_search_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_md5_search_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md5_search_pkg.sv
// Shared definitions for the MD5 candidate-search controller.
//   - search_state_e : controller FSM encoding (IDLE, RUN, DRAIN, DONE)
//   - MD5_PIPE_LATENCY : cycles from core_message to core_hash (pad reg,
//     64 rounds, output reg)
//   - MD5_MSG_W / MD5_LEN_W / MD5_HASH_W : md5core bus widths
//   - MD5_IV_A..D : MD5 initial chaining values, used by bench-side models
package md5_search_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } search_state_e;

    localparam int MD5_PIPE_LATENCY = 66;
    localparam int MD5_MSG_W        = 448;
    localparam int MD5_LEN_W        = 64;
    localparam int MD5_HASH_W       = 128;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

endpackage

// File: rtl/md5_search_ctrl_if.sv
// Host-side job interface of md5_search_ctrl.
//   master : host / register block (drives the job, reads status)
//   slave  : md5_search_ctrl
// Handshake: start is a one-cycle pulse accepted only while busy is low and
// done is not pulsing; the job inputs are sampled on that same edge. busy is
// high from the cycle after an accepted start until done. done is a one-cycle
// pulse; found/found_idx are valid with done and held until the next start.
// abort is a one-cycle pulse honoured only while busy. dbg_state mirrors the
// controller FSM state.
interface md5_search_ctrl_if
    import md5_search_pkg::*;
#(
    parameter int IDX_W = 16
);
    logic                  start;
    logic                  abort;
    logic [MD5_MSG_W-1:0]  base_msg;
    logic [MD5_LEN_W-1:0]  msg_len;
    logic [IDX_W-1:0]      idx_start;
    logic [IDX_W-1:0]      idx_end;
    logic [MD5_HASH_W-1:0] target;
    logic                  busy;
    logic                  done;
    logic                  found;
    logic [IDX_W-1:0]      found_idx;
    search_state_e         dbg_state;

    modport master (
        output start, abort, base_msg, msg_len, idx_start, idx_end, target,
        input  busy, done, found, found_idx, dbg_state
    );

    modport slave (
        input  start, abort, base_msg, msg_len, idx_start, idx_end, target,
        output busy, done, found, found_idx, dbg_state
    );
endinterface

// File: rtl/md5_valid_pipe.sv
// Valid-tag shift register that tracks which md5core pipeline slots carry a
// real candidate.
//   clk, rst_n : clock, asynchronous active-low reset (clears all tags)
//   in_i       : tag entering the pipe this cycle
//   tap_o      : tag at depth DEPTH (core_hash valid)
//   empty_o    : no tag anywhere in the pipe
module md5_valid_pipe #(
    parameter int DEPTH = 66
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic tap_o,
    output logic empty_o
);
    logic [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= {pipe_q[DEPTH-2:0], in_i};
        end
    end

    assign tap_o   = pipe_q[DEPTH-1];
    assign empty_o = ~|pipe_q;
endmodule

// File: rtl/md5_search_ctrl.sv
// Candidate-sweep controller for the fully pipelined md5core. Issues one
// candidate per cycle ({base_msg[447:IDX_W], idx}), tracks in-flight slots
// with a valid pipe, compares each retiring hash against the target and
// reports the first matching index or exhaustion of the range.
//   clk, rst_n   : clock, asynchronous active-low reset
//   host         : job interface (start/abort/job fields in, busy/done/found out)
//   core_message : candidate message to md5core (holds when not issuing)
//   core_length  : message length to md5core
//   core_hash    : digest from md5core, qualified only by the valid pipe
//   perf_cycles, perf_checked : only with MD5_SEARCH_PERF_EN defined; busy
//                  cycles and retired hashes of the last job, saturating
module md5_search_ctrl
    import md5_search_pkg::*;
#(
    parameter int IDX_W        = 16,
    parameter int PIPE_LATENCY = MD5_PIPE_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    md5_search_ctrl_if.slave      host,
    output logic [MD5_MSG_W-1:0]  core_message,
    output logic [MD5_LEN_W-1:0]  core_length,
    input  logic [MD5_HASH_W-1:0] core_hash
`ifdef MD5_SEARCH_PERF_EN
    ,
    output logic [31:0]           perf_cycles,
    output logic [31:0]           perf_checked
`endif
);
    search_state_e               state_q, state_d;
    logic [MD5_MSG_W-1:IDX_W]    base_q;
    logic [MD5_LEN_W-1:0]        len_q;
    logic [IDX_W-1:0]            end_q;
    logic [MD5_HASH_W-1:0]       target_q;
    logic [IDX_W-1:0]            issue_idx_q, issue_idx_d;
    logic [IDX_W-1:0]            retire_idx_q, retire_idx_d;
    logic                        found_q, found_d;
    logic [IDX_W-1:0]            found_idx_q, found_idx_d;
    // Set once the result is decided (match or abort); later matches are ignored.
    logic                        stop_q, stop_d;
    // Registered issue strobe: qualifies the candidate currently on core_message.
    logic                        issue_q, issue_d;
    logic [MD5_MSG_W-1:0]        core_message_q, core_message_d;
    logic [MD5_LEN_W-1:0]        core_length_q, core_length_d;
    logic                        latch_job;
    logic                        tap;
    logic                        pipe_empty;
    logic                        match_hit;

    // The core_message register is the first slot, so the pipe is fed from
    // issue_q and its tap lands on the cycle core_hash belongs to that slot.
    md5_valid_pipe #(.DEPTH(PIPE_LATENCY)) u_valid_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_i   (issue_q),
        .tap_o  (tap),
        .empty_o(pipe_empty)
    );

    assign match_hit = tap && (core_hash == target_q) && !stop_q;

    always_comb begin
        state_d        = state_q;
        issue_idx_d    = issue_idx_q;
        retire_idx_d   = retire_idx_q;
        found_d        = found_q;
        found_idx_d    = found_idx_q;
        stop_d         = stop_q;
        issue_d        = 1'b0;
        core_message_d = core_message_q;
        core_length_d  = core_length_q;
        latch_job      = 1'b0;

        // Retirement is in order, so counting taps names each result.
        if (tap) begin
            retire_idx_d = retire_idx_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    latch_job    = 1'b1;
                    issue_idx_d  = host.idx_start;
                    retire_idx_d = host.idx_start;
                    found_d      = 1'b0;
                    found_idx_d  = '0;
                    stop_d       = 1'b0;
                    state_d      = (host.idx_start > host.idx_end) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // A match wins over a coincident abort.
                if (match_hit) begin
                    found_d     = 1'b1;
                    found_idx_d = retire_idx_q;
                    stop_d      = 1'b1;
                    state_d     = ST_DRAIN;
                end else if (host.abort) begin
                    stop_d  = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    issue_d        = 1'b1;
                    core_message_d = {base_q, issue_idx_q};
                    core_length_d  = len_q;
                    issue_idx_d    = issue_idx_q + 1'b1;
                    // Leave on the last index so issue_idx never wraps into use.
                    if (issue_idx_q == end_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (match_hit) begin
                    found_d     = 1'b1;
                    found_idx_d = retire_idx_q;
                    stop_d      = 1'b1;
                end else if (host.abort) begin
                    stop_d = 1'b1;
                end
                if (pipe_empty && !issue_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            len_q          <= '0;
            end_q          <= '0;
            target_q       <= '0;
            issue_idx_q    <= '0;
            retire_idx_q   <= '0;
            found_q        <= 1'b0;
            found_idx_q    <= '0;
            stop_q         <= 1'b0;
            issue_q        <= 1'b0;
            core_message_q <= '0;
            core_length_q  <= '0;
        end else begin
            state_q        <= state_d;
            issue_idx_q    <= issue_idx_d;
            retire_idx_q   <= retire_idx_d;
            found_q        <= found_d;
            found_idx_q    <= found_idx_d;
            stop_q         <= stop_d;
            issue_q        <= issue_d;
            core_message_q <= core_message_d;
            core_length_q  <= core_length_d;
            if (latch_job) begin
                base_q   <= host.base_msg[MD5_MSG_W-1:IDX_W];
                len_q    <= host.msg_len;
                end_q    <= host.idx_end;
                target_q <= host.target;
            end
        end
    end

    assign host.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign host.done      = (state_q == ST_DONE);
    assign host.found     = found_q;
    assign host.found_idx = found_idx_q;
    assign host.dbg_state = state_q;
    assign core_message   = core_message_q;
    assign core_length    = core_length_q;

`ifdef MD5_SEARCH_PERF_EN
    logic [31:0] perf_cycles_q;
    logic [31:0] perf_checked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q  <= '0;
            perf_checked_q <= '0;
        end else if (latch_job) begin
            perf_cycles_q  <= '0;
            perf_checked_q <= '0;
        end else begin
            if (host.busy && (perf_cycles_q != '1)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (tap && (perf_checked_q != '1)) begin
                perf_checked_q <= perf_checked_q + 32'd1;
            end
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_checked = perf_checked_q;
`endif
endmodule

// File: tb/tb_md5_search_ctrl.sv
// Bench for md5_search_ctrl with IDX_W = 8. md5core is replaced by a
// behavioural stand-in: a PIPE_LATENCY-deep register chain carrying a cheap
// keyed mix of (core_message, core_length). The mix is a bijection of the low
// message word, so every candidate index yields a distinct digest, which is
// all the controller relies on. Define MD5_SEARCH_PERF_EN to cover the
// performance counters as well.
module tb_md5_search_ctrl;
    import md5_search_pkg::*;

    localparam int IDX_W = 8;
    localparam int LAT   = MD5_PIPE_LATENCY;
    localparam int W     = 1 + IDX_W;

    logic clk;
    logic rst_n;
    logic [MD5_MSG_W-1:0]  core_message;
    logic [MD5_LEN_W-1:0]  core_length;
    logic [MD5_HASH_W-1:0] core_hash;
`ifdef MD5_SEARCH_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_checked;
`endif

    md5_search_ctrl_if #(.IDX_W(IDX_W)) h ();

    md5_search_ctrl #(.IDX_W(IDX_W), .PIPE_LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (h),
        .core_message(core_message),
        .core_length (core_length),
        .core_hash   (core_hash)
`ifdef MD5_SEARCH_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_checked(perf_checked)
`endif
    );

    // ---------------- clock / reset / cycle counter ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- core stand-in ----------------
    function automatic logic [127:0] model_hash(input logic [447:0] m, input logic [63:0] l);
        logic [127:0] x;
        x = {MD5_IV_A, MD5_IV_B, MD5_IV_C, MD5_IV_D};
        for (int i = 0; i < 14; i++) begin
            x[31:0]  = x[31:0] ^ (m[i*32 +: 32] * 32'h9e3779b1);
            x        = {x[95:0], x[127:96]};
            x[63:32] = x[63:32] + x[31:0];
        end
        return x ^ {l, l};
    endfunction

    logic [127:0] hpipe [LAT];
    always @(posedge clk) begin
        hpipe[0] <= model_hash(core_message, core_length);
        for (int i = 1; i < LAT; i++) hpipe[i] <= hpipe[i-1];
    end
    assign core_hash = hpipe[LAT-1];

    // First cycle the watched index appears on core_message while busy.
    int         first_hit = -1;
    logic [7:0] watch_idx = 8'h00;
    always @(negedge clk) begin
        if (first_hit < 0 && h.busy && core_message[7:0] == watch_idx) first_hit = cyc;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;
    int n_vec = 0;
    int n_err = 0;

    // ---------------- driver tasks ----------------
    function automatic logic [447:0] rand_base();
        logic [447:0] r;
        for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [447:0] with_idx(input logic [447:0] b, input logic [7:0] k);
        logic [447:0] m;
        m = b;
        m[7:0] = k;
        return m;
    endfunction

    task automatic drive_start(input logic [447:0] b, input logic [63:0] l, input logic [7:0] s,
                               input logic [7:0] e, input logic [127:0] t, output int sc);
        @(negedge clk);
        h.base_msg  = b;
        h.msg_len   = l;
        h.idx_start = s;
        h.idx_end   = e;
        h.target    = t;
        h.start     = 1'b1;
        @(posedge clk);
        #1;
        sc = cyc;
        h.start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit tmo, output int busy_cyc, output int done_cyc);
        tmo = 1'b1;
        busy_cyc = 0;
        done_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (h.busy) busy_cyc++;
            if (h.done) begin
                tmo = 1'b0;
                done_cyc = cyc;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        h.start = 1'b0; h.abort = 1'b0;
        h.base_msg = '0; h.msg_len = '0; h.idx_start = '0; h.idx_end = '0; h.target = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (h.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b exp 0", h.busy); end
        n_vec++; if (h.done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b exp 0", h.done); end
        n_vec++; if ({h.found, h.found_idx} !== 9'h000) begin n_err++; $display("FAIL reset_found got %h exp 000", {h.found, h.found_idx}); end
        n_vec++; if (core_message !== '0) begin n_err++; $display("FAIL reset_core_message got nonzero exp 0"); end
        n_vec++; if (core_length !== '0) begin n_err++; $display("FAIL reset_core_length got %h exp 0", core_length); end
        n_vec++; if (h.dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp 0", h.dbg_state); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (h.busy !== 1'b0 || h.done !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy %0b done %0b exp 0 0", h.busy, h.done); end
    endtask

    task automatic test_find_abc();
        logic [447:0] b;
        int sc, bc, dc;
        bit tmo;
        b = '0;
        b[23:8] = 16'h6162;
        first_hit = -1;
        watch_idx = 8'h63;
        exp_q.push_back({1'b1, 8'h63});
        drive_start(b, 64'd24, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h63), 64'd24), sc);
        @(negedge clk);
        n_vec++; if (h.busy !== 1'b1) begin n_err++; $display("FAIL abc_busy_rise got %0b exp 1", h.busy); end
        wait_done(2000, tmo, bc, dc);
        n_vec++; if (tmo) begin n_err++; $display("FAIL abc_timeout got no done exp done"); end
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v) begin n_err++; $display("FAIL abc_result got %h exp %h", {h.found, h.found_idx}, exp_v); end
        n_vec++; if (first_hit !== sc + 1 + 8'h63) begin n_err++; $display("FAIL abc_issue_cycle got %0d exp %0d", first_hit, sc + 1 + 8'h63); end
        // Match retires LAT cycles after issue; candidates issued up to then drain for LAT+2 more.
        n_vec++; if (dc - first_hit !== 2 * LAT + 2) begin n_err++; $display("FAIL abc_done_latency got %0d exp %0d", dc - first_hit, 2 * LAT + 2); end
        @(negedge clk);
        n_vec++; if (h.done !== 1'b0 || h.busy !== 1'b0) begin n_err++; $display("FAIL abc_done_pulse done %0b busy %0b exp 0 0", h.done, h.busy); end
        n_vec++; if ({h.found, h.found_idx} !== 9'h163) begin n_err++; $display("FAIL abc_hold got %h exp 163", {h.found, h.found_idx}); end
    endtask

    task automatic test_no_match();
        logic [447:0] b;
        int sc, bc, dc;
        bit tmo;
        b = rand_base();
        exp_q.push_back({1'b0, 8'h00});
        // Digest for a different length: no candidate of this job can produce it.
        drive_start(b, 64'd40, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h00), 64'd41), sc);
        wait_done(2000, tmo, bc, dc);
        n_vec++; if (tmo) begin n_err++; $display("FAIL nomatch_timeout got no done exp done"); end
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v) begin n_err++; $display("FAIL nomatch_result got %h exp %h", {h.found, h.found_idx}, exp_v); end
        n_vec++; if (bc !== 256 + LAT + 2) begin n_err++; $display("FAIL nomatch_busy_len got %0d exp %0d", bc, 256 + LAT + 2); end
`ifdef MD5_SEARCH_PERF_EN
        n_vec++; if (perf_checked !== 32'd256) begin n_err++; $display("FAIL perf_checked got %0d exp 256", perf_checked); end
        n_vec++; if (perf_cycles !== 32'(bc)) begin n_err++; $display("FAIL perf_cycles got %0d exp %0d", perf_cycles, bc); end
        @(negedge clk);
        n_vec++; if (perf_cycles !== 32'(bc)) begin n_err++; $display("FAIL perf_cycles_hold got %0d exp %0d", perf_cycles, bc); end
`endif
    endtask

    task automatic test_boundaries();
        logic [447:0] b;
        int sc, bc, dc;
        bit tmo;
        // Match on the all-ones index.
        b = rand_base();
        exp_q.push_back({1'b1, 8'hFF});
        drive_start(b, 64'd64, 8'hF0, 8'hFF, model_hash(with_idx(b, 8'hFF), 64'd64), sc);
        wait_done(2000, tmo, bc, dc);
        n_vec++; if (tmo) begin n_err++; $display("FAIL top_idx_timeout got no done exp done"); end
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v) begin n_err++; $display("FAIL top_idx_result got %h exp %h", {h.found, h.found_idx}, exp_v); end
        // Single-index range.
        b = rand_base();
        exp_q.push_back({1'b1, 8'h10});
        drive_start(b, 64'd64, 8'h10, 8'h10, model_hash(with_idx(b, 8'h10), 64'd64), sc);
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL single_idx_result got %h exp %h", {h.found, h.found_idx}, exp_v); end
        n_vec++; if (bc !== 1 + LAT + 2) begin n_err++; $display("FAIL single_idx_busy_len got %0d exp %0d", bc, 1 + LAT + 2); end
        // Empty (reversed) range goes straight to done.
        exp_q.push_back({1'b0, 8'h00});
        drive_start(b, 64'd64, 8'h20, 8'h10, model_hash(with_idx(b, 8'h10), 64'd64), sc);
        wait_done(20, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL empty_range_result got %h exp %h", {h.found, h.found_idx}, exp_v); end
        n_vec++; if (bc !== 0) begin n_err++; $display("FAIL empty_range_busy got %0d exp 0", bc); end
    endtask

    task automatic test_abort();
        logic [447:0] b;
        int sc, bc, dc;
        bit tmo;
        b = rand_base();
        exp_q.push_back({1'b0, 8'h00});
        drive_start(b, 64'd64, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h80), 64'd64), sc);
        repeat (10) @(posedge clk);
        #1 h.abort = 1'b1;
        @(posedge clk);
        #1 h.abort = 1'b0;
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL abort_result got %h exp %h tmo %0b", {h.found, h.found_idx}, exp_v, tmo); end
        // Abort raised in the very cycle the index-0x30 hash retires.
        b = rand_base();
        exp_q.push_back({1'b1, 8'h30});
        drive_start(b, 64'd64, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h30), 64'd64), sc);
        repeat (LAT + 1 + 8'h30) @(posedge clk);
        #1 h.abort = 1'b1;
        @(posedge clk);
        #1 h.abort = 1'b0;
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL abort_match_result got %h exp %h tmo %0b", {h.found, h.found_idx}, exp_v, tmo); end
    endtask

    task automatic test_reset_mid_job();
        logic [447:0] b;
        int sc, bc, dc, spurious;
        bit tmo;
        b = rand_base();
        drive_start(b, 64'd64, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h50), 64'd64), sc);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (h.busy !== 1'b0 || h.done !== 1'b0) begin n_err++; $display("FAIL midrst_busy_done got %0b %0b exp 0 0", h.busy, h.done); end
        n_vec++; if ({h.found, h.found_idx} !== 9'h000) begin n_err++; $display("FAIL midrst_found got %h exp 000", {h.found, h.found_idx}); end
        n_vec++; if (core_message !== '0 || core_length !== '0) begin n_err++; $display("FAIL midrst_core_bus got nonzero exp 0"); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 0;
        repeat (2 * LAT + 20) begin
            @(negedge clk);
            if (h.done || h.busy) spurious++;
        end
        n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL midrst_spurious got %0d active cycles exp 0", spurious); end
        b = rand_base();
        exp_q.push_back({1'b1, 8'h44});
        drive_start(b, 64'd64, 8'h00, 8'hFF, model_hash(with_idx(b, 8'h44), 64'd64), sc);
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL midrst_restart got %h exp %h tmo %0b", {h.found, h.found_idx}, exp_v, tmo); end
    endtask

    task automatic test_back_to_back();
        logic [447:0] ba, bb;
        int sc, bc, dc;
        bit tmo;
        ba = rand_base();
        bb = rand_base();
        exp_q.push_back({1'b1, 8'h05});
        drive_start(ba, 64'd64, 8'h00, 8'h0F, model_hash(with_idx(ba, 8'h05), 64'd64), sc);
        // A start while busy must not disturb the latched job.
        repeat (3) @(negedge clk);
        h.base_msg = bb; h.idx_start = 8'h20; h.idx_end = 8'h30;
        h.target = model_hash(with_idx(bb, 8'h25), 64'd64);
        h.start = 1'b1;
        @(posedge clk);
        #1 h.start = 1'b0;
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL b2b_first got %h exp %h tmo %0b", {h.found, h.found_idx}, exp_v, tmo); end
        exp_q.push_back({1'b1, 8'h25});
        drive_start(bb, 64'd64, 8'h20, 8'h30, model_hash(with_idx(bb, 8'h25), 64'd64), sc);
        wait_done(2000, tmo, bc, dc);
        n_vec++;
        exp_v = exp_q.pop_front();
        if ({h.found, h.found_idx} !== exp_v || tmo) begin n_err++; $display("FAIL b2b_second got %h exp %h tmo %0b", {h.found, h.found_idx}, exp_v, tmo); end
        n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_find_abc();
        test_no_match();
        test_boundaries();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
